// File: rtl/divider_32.sv
`default_nettype none
// ============================================================================
//  Module   : divider_32
//  Purpose  : 32-bit RV32M DIV/DIVU/REM/REMU, restoring, one iteration/cycle.
//             Define DIVIDER_FASTPATH_EN for 1-cycle divide-by-zero/overflow.
//  Revision : 1.0  initial release
// ============================================================================
module divider_32 (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic [31:0] r_dividend;
  logic [4:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_is_rem;
  logic        r_div0;

  logic        w_accept;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div0;
  logic        w_fast;
  logic [31:0] w_fast_result;

  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_q_signed;
  logic [31:0] w_r_signed;
  logic [31:0] w_calc_result;

  // Operand decode at the start edge: magnitudes and result signs.
  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_signed = ~i_op[0];
  assign w_a_neg  = w_signed & i_dividend[31];
  assign w_b_neg  = w_signed & i_divisor[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - i_dividend) : i_dividend;
  assign w_b_mag  = w_b_neg ? (32'd0 - i_divisor) : i_divisor;
  assign w_div0   = (i_divisor == 32'd0);

`ifdef DIVIDER_FASTPATH_EN
  logic w_ovf;
  assign w_ovf  = w_signed && (i_dividend == 32'h8000_0000) && (i_divisor == 32'hFFFF_FFFF);
  assign w_fast = w_div0 | w_ovf;
`else
  assign w_fast = 1'b0;
`endif

  assign w_fast_result = w_div0 ? (i_op[1] ? i_dividend : 32'hFFFF_FFFF)
                                : (i_op[1] ? 32'd0      : 32'h8000_0000);

  // One restoring step; the partial remainder always stays below the divisor,
  // so 32 bits of the difference are enough.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_ge       = (w_shift >= {1'b0, r_dvs});
  assign w_sub      = w_shift[31:0] - r_dvs;
  assign w_rem_next = w_ge ? w_sub : w_shift[31:0];
  assign w_quo_next = {r_quo[30:0], w_ge};

  assign w_q_signed = r_neg_q ? (32'd0 - w_quo_next) : w_quo_next;
  assign w_r_signed = r_neg_r ? (32'd0 - w_rem_next) : w_rem_next;
  // Divide-by-zero needs an override: sign fix-up would corrupt the all-ones quotient.
  assign w_calc_result = r_div0   ? (r_is_rem ? r_dividend : 32'hFFFF_FFFF)
                                  : (r_is_rem ? w_r_signed : w_q_signed);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = w_fast ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (i_abort) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == 5'd31) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_quo      <= 32'd0;
      r_rem      <= 32'd0;
      r_dvs      <= 32'd0;
      r_dividend <= 32'd0;
      r_cnt      <= 5'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_is_rem   <= 1'b0;
      r_div0     <= 1'b0;
      o_result   <= 32'd0;
    end else if (w_accept) begin
      r_quo      <= w_a_mag;
      r_rem      <= 32'd0;
      r_dvs      <= w_b_mag;
      r_dividend <= i_dividend;
      r_cnt      <= 5'd0;
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_is_rem   <= i_op[1];
      r_div0     <= w_div0;
      if (w_fast) begin
        o_result <= w_fast_result;
      end
    end else if ((r_state == ST_CALC) && !i_abort) begin
      r_quo <= w_quo_next;
      r_rem <= w_rem_next;
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) begin
        o_result <= w_calc_result;
      end
    end
  end

  assign o_busy = (r_state == ST_CALC);
  assign o_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_divider_32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divider_32
//  Purpose  : Randomized self-checking bench for divider_32 against an
//             arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_divider_32;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'd0;
  logic [31:0] i_dividend = 32'd0;
  logic [31:0] i_divisor = 32'd0;
  logic        i_abort = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_result = 32'd0;

  localparam logic [1:0] c_div  = 2'b00;
  localparam logic [1:0] c_divu = 2'b01;
  localparam logic [1:0] c_rem  = 2'b10;
  localparam logic [1:0] c_remu = 2'b11;

  divider_32 dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .i_abort    (i_abort),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // RV32M semantics: SV signed / and % truncate toward zero like RISC-V.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      c_div:   return 32'(sa / sb);
      c_rem:   return 32'(sa % sb);
      c_divu:  return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef DIVIDER_FASTPATH_EN
    if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`else
    if (op == 2'b00 && a == 32'd0 && b == 32'd0) return 33;
`endif
    return 33;
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit with_abort, input string tag);
    int          cyc;
    bit          got;
    int          lat;
    logic [31:0] exp;
    cyc = 0;
    got = 1'b0;
    exp = model(op, a, b);
    lat = exp_latency(op, a, b);
    i_op = op;
    i_dividend = a;
    i_divisor = b;
    i_start = 1'b1;
    i_abort = with_abort;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_op = 2'($urandom);
    i_dividend = $urandom;
    i_divisor = $urandom;
    while (!got && cyc < 40) begin
      @(negedge i_clk);
      cyc++;
      if (cyc == 1) check({tag, " busy"}, 32'(o_busy), 32'(lat > 1));
      if (o_done) got = 1'b1;
    end
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    check({tag, " result"}, o_result, exp);
    @(negedge i_clk);
    check({tag, " done pulse"}, {30'd0, o_done, o_busy}, 32'd0);
    check({tag, " hold"}, o_result, exp);
    last_result = exp;
  endtask

  initial begin
    int          dones;
    int          done_cyc;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (3) @(negedge i_clk);
    check("reset busy", 32'(o_busy), 32'd0);
    check("reset done", 32'(o_done), 32'd0);
    check("reset result", o_result, 32'd0);
    i_rst_n = 1'b1;

    do_div(c_divu, 32'd100, 32'd7, 1'b0, "divu 100/7");
    do_div(c_remu, 32'd100, 32'd7, 1'b0, "remu 100/7");
    do_div(c_div, 32'hFFFF_FFF9, 32'd2, 1'b0, "div -7/2");
    do_div(c_rem, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem -7/2");
    do_div(c_divu, 32'd5, 32'd0, 1'b0, "divu 5/0");
    do_div(c_rem, 32'd5, 32'd0, 1'b0, "rem 5/0");
    do_div(c_div, 32'hFFFF_FFF9, 32'd0, 1'b0, "div -7/0");
    do_div(c_div, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div ovf");
    do_div(c_rem, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem ovf");
    do_div(c_divu, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divu big");
    do_div(c_rem, 32'd17, 32'hFFFF_FFFB, 1'b1, "rem start+abort");

    // Start pulsed mid-calculation must be ignored and not queued.
    i_op = c_divu; i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    dones = 0;
    done_cyc = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge i_clk);
      if (c == 10) begin
        i_start = 1'b1; i_op = c_div; i_dividend = 32'd50; i_divisor = 32'd5;
      end else begin
        i_start = 1'b0;
      end
      if (o_done) begin
        dones++;
        done_cyc = c;
      end
    end
    check("ignored start dones", 32'(dones), 32'd1);
    check("ignored start latency", 32'(done_cyc), 32'd33);
    check("ignored start result", o_result, 32'd14);
    last_result = 32'd14;

    // Abort in calculation cycle 5.
    i_op = c_divu; i_dividend = 32'd1000; i_divisor = 32'd3; i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (5) @(negedge i_clk);
    i_abort = 1'b1;
    @(posedge i_clk);
    #1;
    i_abort = 1'b0;
    check("abort busy", 32'(o_busy), 32'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_done) dones++;
    end
    check("abort dones", 32'(dones), 32'd0);
    check("abort result", o_result, last_result);
    do_div(c_divu, 32'd9, 32'd3, 1'b0, "divu 9/3 after abort");

    // Reset in calculation cycle 20.
    i_op = c_div; i_dividend = 32'h1234_5678; i_divisor = 32'd3; i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (20) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("mid reset state", {30'd0, o_done, o_busy}, 32'd0);
    check("mid reset result", o_result, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_div(c_divu, 32'd9, 32'd3, 1'b0, "divu 9/3 after reset");

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 40); end
        3: rb = rb >> $urandom_range(8, 31);
        default: ;
      endcase
      do_div(rop, ra, rb, 1'b0, $sformatf("rand%0d op%0d 0x%08h/0x%08h", n, rop, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
